systolic_array_ctrl: RTL and testbench

Sequencing controller for the N×N FP16 systolic array of ProcessingElement instances. On a start command it clears the PE accumulators and fetches K column/row vectors from the operand buffers. It applies the diagonal skew so that row i / column j receive their operands i / j cycles late, with zeros inserted elsewhere. It then drains the wavefront and pulses done when every PE_out holds the final dot product.

---
 rtl/systolic_array_ctrl.sv | 150 +++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl
// Sequences an N x N systolic array run: clears the PE accumulators, fetches
// k_len operand vectors, applies the diagonal skew on the array edges, waits
// for the wavefront to drain and then pulses done.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; all strobes low
// S_CLEAR | one cycle of pe_clear
// S_FEED  | fetch_en high, fetch_idx walks 0..k_lat-1
// S_DRAIN | down-counter lets the last operands propagate through the array
// S_DONE  | one-cycle done pulse

module systolic_array_ctrl #(
    parameter  int DATA_WIDTH = 16,
    parameter  int N          = 4,
    parameter  int K_MAX      = 16,
    parameter  int PE_LAT     = 2,
    localparam int K_W        = $clog2(K_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    output logic                    fetch_en,
    output logic [K_W-1:0]          fetch_idx,
    input  logic [N*DATA_WIDTH-1:0] a_col_in,
    input  logic [N*DATA_WIDTH-1:0] b_row_in,
    output logic [N*DATA_WIDTH-1:0] edge_a,
    output logic [N*DATA_WIDTH-1:0] edge_b,
    output logic                    pe_clear,
    output logic                    busy,
    output logic                    done
);

    // Drain length: the last operand needs 2*(N-1) skew/propagation cycles to
    // reach the far corner PE, plus the buffer and edge register stages and
    // the PE latency.
    localparam int D   = 2 * N + PE_LAT;
    localparam int D_W = $clog2(D + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [K_W-1:0] k_lat;
    logic [D_W-1:0] drain_cnt;
    logic           valid_q;
    logic           feed_last;

    assign feed_last = (fetch_idx == (k_lat - K_W'(1)));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = (k_lat == '0) ? S_DRAIN : S_FEED;
            S_FEED:  if (feed_last) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        fetch_en = (state == S_FEED);
        pe_clear = (state == S_CLEAR);
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
    end

    // Latch the inner dimension on an accepted start, clamped to K_MAX.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_lat <= '0;
        end else if ((state == S_IDLE) && start) begin
            k_lat <= (k_len > K_W'(K_MAX)) ? K_W'(K_MAX) : k_len;
        end
    end

    // Fetch index: zeroed in CLEAR, steps during FEED, holds the last index afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_idx <= '0;
        end else if (state == S_CLEAR) begin
            fetch_idx <= '0;
        end else if ((state == S_FEED) && !feed_last) begin
            fetch_idx <= fetch_idx + K_W'(1);
        end
    end

    // Drain timer: loaded on entry to DRAIN, terminal count at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= '0;
        end else if ((state_nxt == S_DRAIN) && (state != S_DRAIN)) begin
            drain_cnt <= D_W'(D - 1);
        end else if ((state == S_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - D_W'(1);
        end
    end

    // Buffer read data is valid one cycle after the fetch strobe.
    always_ff @(posedge clk) begin
        if (reset) valid_q <= 1'b0;
        else       valid_q <= fetch_en;
    end

    // Skew chains: lane i gets a capture stage plus i delay stages. Non-valid
    // cycles load zeros so idle PE products are +0.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_stg [0:i];
        logic [DATA_WIDTH-1:0] b_stg [0:i];

        // Capture on valid, then shift down the lane.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) begin
                    a_stg[s] <= '0;
                    b_stg[s] <= '0;
                end
            end else begin
                a_stg[0] <= valid_q ? a_col_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                b_stg[0] <= valid_q ? b_row_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
                for (int s = 1; s <= i; s++) begin
                    a_stg[s] <= a_stg[s-1];
                    b_stg[s] <= b_stg[s-1];
                end
            end
        end

        assign edge_a[i*DATA_WIDTH +: DATA_WIDTH] = a_stg[i];
        assign edge_b[i*DATA_WIDTH +: DATA_WIDTH] = b_stg[i];
    end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Testbench for systolic_array_ctrl: table of runs plus randomized runs,
// checked cycle by cycle against a timing model derived from the run length.

module tb_systolic_array_ctrl;

    localparam int DW     = 16;
    localparam int N      = 4;
    localparam int K_MAX  = 16;
    localparam int PE_LAT = 2;
    localparam int K_W    = $clog2(K_MAX + 1);
    localparam int D      = 2 * N + PE_LAT;
    localparam int EW     = N * DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [K_W-1:0] k_len;
    logic          fetch_en;
    logic [K_W-1:0] fetch_idx;
    logic [EW-1:0] a_col_in;
    logic [EW-1:0] b_row_in;
    logic [EW-1:0] edge_a;
    logic [EW-1:0] edge_b;
    logic          pe_clear;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] mat_a [K_MAX][N];
    logic [DW-1:0] mat_b [K_MAX][N];

    systolic_array_ctrl #(
        .DATA_WIDTH(DW), .N(N), .K_MAX(K_MAX), .PE_LAT(PE_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .fetch_en(fetch_en), .fetch_idx(fetch_idx),
        .a_col_in(a_col_in), .b_row_in(b_row_in),
        .edge_a(edge_a), .edge_b(edge_b),
        .pe_clear(pe_clear), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: random data, 1: all 2.0 x 3.0, 2: mixed-sign lane 0 example
    task automatic fill_data(input int mode);
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < N; i++) begin
                mat_a[k][i] = 16'($urandom_range(1, 16'hffff));
                mat_b[k][i] = 16'($urandom_range(1, 16'hffff));
                if (mode == 1) begin
                    mat_a[k][i] = 16'h4000;
                    mat_b[k][i] = 16'h4200;
                end
            end
        end
        if (mode == 2) begin
            mat_a[0][0] = 16'h459a; mat_a[1][0] = 16'hc866; mat_a[2][0] = 16'h0000;
            mat_b[0][0] = 16'h4266; mat_b[1][0] = 16'h40cd; mat_b[2][0] = 16'h0000;
        end
    endtask

    // One run from start at cycle 0. glitch_c: cycle with an extra start
    // (ignored by the DUT); rst_c: cycle in which reset is asserted.
    task automatic run(input int k_in, input int glitch_c, input int glitch_k,
                       input int rst_c, output int n_fetch, output int done_c);
        int kl, last, c_end, kk;
        bit prev_fe;
        int prev_idx;
        logic [EW-1:0] ea, eb;
        kl      = (k_in > K_MAX) ? K_MAX : k_in;
        last    = kl + 2 + D;
        c_end   = (rst_c >= 0) ? rst_c + 1 : last + 1;
        n_fetch = 0;
        done_c  = -1;
        prev_fe = 1'b0;
        prev_idx = 0;
        for (int c = 0; c <= c_end; c++) begin
            start = (c == 0) || (c == glitch_c);
            k_len = (c == 0) ? K_W'(k_in) : (c == glitch_c) ? K_W'(glitch_k) : K_W'($urandom);
            reset = (c == rst_c);
            a_col_in = {$urandom, $urandom};
            b_row_in = {$urandom, $urandom};
            if (prev_fe && prev_idx < K_MAX) begin
                for (int i = 0; i < N; i++) begin
                    a_col_in[i*DW +: DW] = mat_a[prev_idx][i];
                    b_row_in[i*DW +: DW] = mat_b[prev_idx][i];
                end
            end
            #0;
            if (rst_c >= 0 && c == rst_c + 1) begin
                chk("rst_fetch_en", EW'(fetch_en), '0);
                chk("rst_fetch_idx", EW'(fetch_idx), '0);
                chk("rst_pe_clear", EW'(pe_clear), '0);
                chk("rst_busy", EW'(busy), '0);
                chk("rst_done", EW'(done), '0);
                chk("rst_edge_a", edge_a, '0);
                chk("rst_edge_b", edge_b, '0);
            end else begin
                ea = '0;
                eb = '0;
                for (int i = 0; i < N; i++) begin
                    kk = c - 4 - i;
                    if (kk >= 0 && kk < kl) begin
                        ea[i*DW +: DW] = mat_a[kk][i];
                        eb[i*DW +: DW] = mat_b[kk][i];
                    end
                end
                chk("pe_clear", EW'(pe_clear), EW'(c == 1));
                chk("fetch_en", EW'(fetch_en), EW'(c >= 2 && c <= kl + 1));
                if (c >= 2 && c <= kl + 1) chk("fetch_idx", EW'(fetch_idx), EW'(c - 2));
                chk("busy", EW'(busy), EW'(c >= 1 && c <= last));
                chk("done", EW'(done), EW'(c == last));
                chk("edge_a", edge_a, ea);
                chk("edge_b", edge_b, eb);
            end
            if (fetch_en) n_fetch++;
            if (done && done_c < 0) done_c = c;
            prev_fe  = fetch_en;
            prev_idx = int'(fetch_idx);
            tick();
        end
        start = 1'b0;
        reset = 1'b0;
    endtask

    typedef struct {
        int k_in;
        int glitch_c;
        int glitch_k;
        int rst_c;
        int mode;
        int exp_fetch;
        int exp_done;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int nf, dc, kin, kl, gc;
        vecs[0] = '{1,  -1, 0,  -1, 1, 1,  13};
        vecs[1] = '{3,  -1, 0,  -1, 2, 3,  15};
        vecs[2] = '{0,  -1, 0,  -1, 0, 0,  12};
        vecs[3] = '{5,   4, 9,  -1, 0, 5,  17};
        vecs[4] = '{20, -1, 0,  -1, 0, 16, 28};
        vecs[5] = '{16,  9, 2,  -1, 0, 16, 28};
        vecs[6] = '{4,  -1, 0,   3, 0, 2,  -1};
        vecs[7] = '{2,  -1, 0,  -1, 0, 2,  14};

        reset = 1'b1; start = 1'b0; k_len = '0; a_col_in = '0; b_row_in = '0;
        tick(); tick(); tick();
        chk("reset_fetch_en", EW'(fetch_en), '0);
        chk("reset_fetch_idx", EW'(fetch_idx), '0);
        chk("reset_pe_clear", EW'(pe_clear), '0);
        chk("reset_busy", EW'(busy), '0);
        chk("reset_done", EW'(done), '0);
        chk("reset_edge_a", edge_a, '0);
        chk("reset_edge_b", edge_b, '0);
        reset = 1'b0;
        tick();

        foreach (vecs[v]) begin
            fill_data(vecs[v].mode);
            run(vecs[v].k_in, vecs[v].glitch_c, vecs[v].glitch_k, vecs[v].rst_c, nf, dc);
            chk($sformatf("vec%0d_fetches", v), EW'(nf), EW'(vecs[v].exp_fetch));
            chk($sformatf("vec%0d_done_cycle", v), EW'(dc), EW'(vecs[v].exp_done));
        end

        // Lane 0 of the mixed-sign example, re-run with explicit expectations.
        fill_data(2);
        begin
            logic [DW-1:0] seq [6];
            seq = '{16'h459a, 16'hc866, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
            start = 1'b1; k_len = K_W'(3);
            for (int c = 0; c <= 16; c++) begin
                if (c > 0) start = 1'b0;
                a_col_in = '0; b_row_in = '0;
                if (c >= 3 && c <= 5) begin
                    for (int i = 0; i < N; i++) begin
                        a_col_in[i*DW +: DW] = mat_a[c-3][i];
                        b_row_in[i*DW +: DW] = mat_b[c-3][i];
                    end
                end
                #0;
                if (c >= 4 && c <= 9) begin
                    chk($sformatf("lane0_a_c%0d", c), EW'(edge_a[DW-1:0]), EW'(seq[c-4]));
                end
                if (c == 4) chk("lane0_b_c4", EW'(edge_b[DW-1:0]), EW'(16'h4266));
                if (c == 5) chk("lane0_b_c5", EW'(edge_b[DW-1:0]), EW'(16'h40cd));
                if (c == 15) chk("lane0_done_c15", EW'(done), 1);
                tick();
            end
        end

        // Back-to-back: start held high gives one run per k_len+3+D cycles.
        begin
            int n_done;
            n_done = 0;
            for (int c = 0; c <= 30; c++) begin
                start = (c < 30);
                k_len = K_W'(2);
                a_col_in = {$urandom, $urandom};
                b_row_in = {$urandom, $urandom};
                #0;
                chk("b2b_done", EW'(done), EW'(c == 14 || c == 29));
                chk("b2b_pe_clear", EW'(pe_clear), EW'(c == 1 || c == 16));
                if (done) n_done++;
                tick();
            end
            start = 1'b0;
            chk("b2b_done_count", EW'(n_done), 2);
        end

        // Randomized runs, including an ignored mid-run start.
        for (int r = 0; r < 20; r++) begin
            kin = $urandom_range(0, 20);
            kl  = (kin > K_MAX) ? K_MAX : kin;
            gc  = $urandom_range(1, kl + 2 + D);
            fill_data(0);
            run(kin, gc, $urandom_range(0, 31), -1, nf, dc);
            chk("rand_fetches", EW'(nf), EW'(kl));
            chk("rand_done_cycle", EW'(dc), EW'(kl + 2 + D));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
